// File: rtl/id_ctrl_pipe_pkg.sv
// Shared decode codes, the EX control bundle and FSM states for the ID control stage.
// Opcode, immediate, memory, ALU and operand-source encodings used across the pipeline.
package id_ctrl_pipe_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] OPC_FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] OPC_FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] OPC_FUNCT7_M    = 7'b0000001;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [2:0] MEM_READ_NONE   = 3'd0;
  localparam logic [2:0] MEM_READ_BYTE   = 3'd1;
  localparam logic [2:0] MEM_READ_HALF   = 3'd2;
  localparam logic [2:0] MEM_READ_WORD   = 3'd3;
  localparam logic [2:0] MEM_READ_BYTE_U = 3'd4;
  localparam logic [2:0] MEM_READ_HALF_U = 3'd5;

  localparam logic [1:0] MEM_WRITE_NONE = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  localparam logic [4:0] ALU_ADD      = 5'h00;
  localparam logic [4:0] ALU_SUB      = 5'h01;
  localparam logic [4:0] ALU_SLL      = 5'h02;
  localparam logic [4:0] ALU_SLT      = 5'h03;
  localparam logic [4:0] ALU_SLTU     = 5'h04;
  localparam logic [4:0] ALU_XOR      = 5'h05;
  localparam logic [4:0] ALU_SRL      = 5'h06;
  localparam logic [4:0] ALU_SRA      = 5'h07;
  localparam logic [4:0] ALU_OR       = 5'h08;
  localparam logic [4:0] ALU_AND      = 5'h09;
  localparam logic [4:0] ALU_LUI      = 5'h0A;
  localparam logic [4:0] ALU_JALR_ADD = 5'h0B;
  localparam logic [4:0] ALU_MUL      = 5'h18;
  localparam logic [4:0] ALU_MULH     = 5'h19;
  localparam logic [4:0] ALU_MULHSU   = 5'h1A;
  localparam logic [4:0] ALU_MULHU    = 5'h1B;
  localparam logic [4:0] ALU_DIV      = 5'h1C;
  localparam logic [4:0] ALU_DIVU     = 5'h1D;
  localparam logic [4:0] ALU_REM      = 5'h1E;
  localparam logic [4:0] ALU_REMU     = 5'h1F;

  localparam logic ALU_A_SRC_RS1 = 1'b0;
  localparam logic ALU_A_SRC_PC  = 1'b1;
  localparam logic ALU_B_SRC_RS2 = 1'b0;
  localparam logic ALU_B_SRC_IMM = 1'b1;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] mem_read;
    logic [1:0] mem_write;
    logic       alu_a_src;
    logic       alu_b_src;
    logic [2:0] imm_type;
    logic [4:0] alu_code;
    logic [5:0] branch_flag;
    logic       wb_en;
    logic [1:0] wb_sel;
    logic       jal_taken;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // alt selects SUB/SRA; callers only raise it where funct7/instr[30] mean that.
  function automatic logic [4:0] base_alu(input logic [2:0] funct3, input logic alt);
    logic [4:0] code;
    code = ALU_ADD;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/id_ctrl_pipe_decode.sv
// Purely combinational RV32I/RV32M decoder: instruction word to EX control bundle,
// illegal flag and multiply/divide class. M-extension decode is gated by ENABLE_M.
module id_decode_comb
  import id_ctrl_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        is_mul_o,
  output logic        is_div_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       bad;
  logic       is_m;
  logic       unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // NOTE: every output is defaulted before the case so no path leaves a value held,
  // which would otherwise infer a latch.
  always_comb begin
    ctrl_o = '0;
    bad    = 1'b0;
    is_m   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_U;
        ctrl_o.alu_code  = ALU_LUI;
        ctrl_o.wb_en     = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.alu_a_src = ALU_A_SRC_PC;
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_U;
        ctrl_o.alu_code  = ALU_ADD;
        ctrl_o.wb_en     = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.alu_a_src = ALU_A_SRC_PC;
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_J;
        ctrl_o.alu_code  = ALU_ADD;
        ctrl_o.wb_en     = 1'b1;
        ctrl_o.wb_sel    = WB_SEL_PC4;
        ctrl_o.jal_taken = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_I;
        ctrl_o.alu_code  = ALU_JALR_ADD;
        ctrl_o.wb_en     = 1'b1;
        ctrl_o.wb_sel    = WB_SEL_PC4;
        ctrl_o.jal_taken = 1'b1;
      end
      OPC_BRANCH: begin
        // ALU forms the target pc+imm; the comparison is chosen by branch_flag.
        ctrl_o.alu_a_src = ALU_A_SRC_PC;
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_B;
        ctrl_o.alu_code  = ALU_ADD;
        case (funct3)
          3'b000:  ctrl_o.branch_flag = 6'b000001;
          3'b001:  ctrl_o.branch_flag = 6'b000010;
          3'b100:  ctrl_o.branch_flag = 6'b000100;
          3'b101:  ctrl_o.branch_flag = 6'b001000;
          3'b110:  ctrl_o.branch_flag = 6'b010000;
          3'b111:  ctrl_o.branch_flag = 6'b100000;
          default: ctrl_o.branch_flag = 6'b000000;
        endcase
      end
      OPC_LOAD: begin
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_I;
        ctrl_o.alu_code  = ALU_ADD;
        ctrl_o.wb_en     = 1'b1;
        ctrl_o.wb_sel    = WB_SEL_MEM;
        case (funct3)
          3'b000:  ctrl_o.mem_read = MEM_READ_BYTE;
          3'b001:  ctrl_o.mem_read = MEM_READ_HALF;
          3'b010:  ctrl_o.mem_read = MEM_READ_WORD;
          3'b100:  ctrl_o.mem_read = MEM_READ_BYTE_U;
          3'b101:  ctrl_o.mem_read = MEM_READ_HALF_U;
          default: ctrl_o.mem_read = MEM_READ_NONE;
        endcase
      end
      OPC_STORE: begin
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_S;
        ctrl_o.alu_code  = ALU_ADD;
        case (funct3)
          3'b000:  ctrl_o.mem_write = MEM_WRITE_BYTE;
          3'b001:  ctrl_o.mem_write = MEM_WRITE_HALF;
          3'b010:  ctrl_o.mem_write = MEM_WRITE_WORD;
          default: ctrl_o.mem_write = MEM_WRITE_NONE;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl_o.alu_b_src = ALU_B_SRC_IMM;
        ctrl_o.imm_type  = IMM_I;
        ctrl_o.alu_code  = base_alu(funct3, (funct3 == 3'b101) && instr_i[30]);
        ctrl_o.wb_en     = 1'b1;
      end
      OPC_OP: begin
        ctrl_o.wb_en = 1'b1;
        case (funct7)
          OPC_FUNCT7_BASE: ctrl_o.alu_code = base_alu(funct3, 1'b0);
          OPC_FUNCT7_ALT: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) ctrl_o.alu_code = base_alu(funct3, 1'b1);
            else                                      bad = 1'b1;
          end
          OPC_FUNCT7_M: begin
            if (ENABLE_M) begin
              ctrl_o.alu_code = ALU_MUL | {2'b00, funct3};
              is_m            = 1'b1;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: bad = 1'b1;
    endcase

    if (bad) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
      is_m           = 1'b0;
    end
  end

  assign is_mul_o = is_m && !funct3[2];
  assign is_div_o = is_m &&  funct3[2];

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID control stage: registers the decoded EX bundle and holds fetch off while a
// multi-cycle multiply/divide occupies EX, using a two-state FSM and latency counter.
module id_ctrl_pipe
  import id_ctrl_pipe_pkg::*;
#(
  parameter bit ENABLE_M    = 1'b1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ex_mem_read,
  output logic [1:0]  ex_mem_write,
  output logic        ex_alu_a_src,
  output logic        ex_alu_b_src,
  output logic [2:0]  ex_imm_type,
  output logic [4:0]  ex_alu_code,
  output logic [5:0]  ex_branch_flag,
  output logic        ex_wb_en,
  output logic [1:0]  ex_wb_sel,
  output logic        ex_jal_taken,
  output logic        ex_md_busy,
  output logic        ex_illegal
);

  localparam int MAX_LAT = max_int(MUL_LATENCY, DIV_LATENCY);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_t      dec_ctrl;
  logic       dec_is_mul;
  logic       dec_is_div;

  md_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       valid_q, valid_d;
  logic       md_busy_q, md_busy_d;
  logic       accept;

  id_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr_i  (instr),
    .ctrl_o   (dec_ctrl),
    .is_mul_o (dec_is_mul),
    .is_div_o (dec_is_div)
  );

  // Ready is a pure function of state so fetch never sees a comb path from instr.
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = '0;
    valid_d   = 1'b0;
    md_busy_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      ctrl_d    = dec_ctrl;
      valid_d   = 1'b1;
      md_busy_d = dec_is_mul || dec_is_div;
      if (dec_is_mul && (MUL_LATENCY > 1)) begin
        state_d = ST_MD_BUSY;
        cnt_d   = MUL_LOAD;
      end else if (dec_is_div && (DIV_LATENCY > 1)) begin
        state_d = ST_MD_BUSY;
        cnt_d   = DIV_LOAD;
      end
    end else if (state_q == ST_MD_BUSY) begin
      // Counter is at least 1 here, so the decrement cannot wrap.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d   = ST_IDLE;
      else                  md_busy_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_alu_a_src   = ctrl_q.alu_a_src;
  assign ex_alu_b_src   = ctrl_q.alu_b_src;
  assign ex_imm_type    = ctrl_q.imm_type;
  assign ex_alu_code    = ctrl_q.alu_code;
  assign ex_branch_flag = ctrl_q.branch_flag;
  assign ex_wb_en       = ctrl_q.wb_en;
  assign ex_wb_sel      = ctrl_q.wb_sel;
  assign ex_jal_taken   = ctrl_q.jal_taken;
  assign ex_md_busy     = md_busy_q;
  assign ex_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed plan steps plus random traffic, compared against a
// mnemonic-level decode table and a stall-count occupancy model for ENABLE_M = 1 and 0.
module tb_id_ctrl_pipe;
  import id_ctrl_pipe_pkg::*;

  localparam int MUL_L = 2;
  localparam int DIV_L = 33;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0000A103;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  typedef struct packed {
    logic       valid;
    logic [2:0] mr;
    logic [1:0] mw;
    logic       a;
    logic       b;
    logic [2:0] imm;
    logic [4:0] alu;
    logic [5:0] br;
    logic       wb_en;
    logic [1:0] wb_sel;
    logic       jal;
    logic       md;
    logic       ill;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        flush;
  logic [31:0] instr;

  logic       m_in_ready, m_ex_valid, m_ex_alu_a_src, m_ex_alu_b_src, m_ex_wb_en;
  logic       m_ex_jal_taken, m_ex_md_busy, m_ex_illegal;
  logic [2:0] m_ex_mem_read, m_ex_imm_type;
  logic [1:0] m_ex_mem_write, m_ex_wb_sel;
  logic [4:0] m_ex_alu_code;
  logic [5:0] m_ex_branch_flag;

  logic       n_in_ready, n_ex_valid, n_ex_alu_a_src, n_ex_alu_b_src, n_ex_wb_en;
  logic       n_ex_jal_taken, n_ex_md_busy, n_ex_illegal;
  logic [2:0] n_ex_mem_read, n_ex_imm_type;
  logic [1:0] n_ex_mem_write, n_ex_wb_sel;
  logic [4:0] n_ex_alu_code;
  logic [5:0] n_ex_branch_flag;

  id_ctrl_pipe #(.ENABLE_M(1'b1), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .in_ready(m_in_ready),
    .flush(flush), .ex_valid(m_ex_valid), .ex_mem_read(m_ex_mem_read),
    .ex_mem_write(m_ex_mem_write), .ex_alu_a_src(m_ex_alu_a_src),
    .ex_alu_b_src(m_ex_alu_b_src), .ex_imm_type(m_ex_imm_type), .ex_alu_code(m_ex_alu_code),
    .ex_branch_flag(m_ex_branch_flag), .ex_wb_en(m_ex_wb_en), .ex_wb_sel(m_ex_wb_sel),
    .ex_jal_taken(m_ex_jal_taken), .ex_md_busy(m_ex_md_busy), .ex_illegal(m_ex_illegal)
  );

  id_ctrl_pipe #(.ENABLE_M(1'b0), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .in_ready(n_in_ready),
    .flush(flush), .ex_valid(n_ex_valid), .ex_mem_read(n_ex_mem_read),
    .ex_mem_write(n_ex_mem_write), .ex_alu_a_src(n_ex_alu_a_src),
    .ex_alu_b_src(n_ex_alu_b_src), .ex_imm_type(n_ex_imm_type), .ex_alu_code(n_ex_alu_code),
    .ex_branch_flag(n_ex_branch_flag), .ex_wb_en(n_ex_wb_en), .ex_wb_sel(n_ex_wb_sel),
    .ex_jal_taken(n_ex_jal_taken), .ex_md_busy(n_ex_md_busy), .ex_illegal(n_ex_illegal)
  );

  obs_t obs_m, obs_n;
  assign obs_m = {m_ex_valid, m_ex_mem_read, m_ex_mem_write, m_ex_alu_a_src, m_ex_alu_b_src,
                  m_ex_imm_type, m_ex_alu_code, m_ex_branch_flag, m_ex_wb_en, m_ex_wb_sel,
                  m_ex_jal_taken, m_ex_md_busy, m_ex_illegal};
  assign obs_n = {n_ex_valid, n_ex_mem_read, n_ex_mem_write, n_ex_alu_a_src, n_ex_alu_b_src,
                  n_ex_imm_type, n_ex_alu_code, n_ex_branch_flag, n_ex_wb_en, n_ex_wb_sel,
                  n_ex_jal_taken, n_ex_md_busy, n_ex_illegal};

  initial forever #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_m, exp_n;
  int   stall_m, stall_n;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference decode, written as the ISA mnemonic table rather than a bit-level decoder.
  function automatic obs_t ref_decode(input logic [31:0] ins, input bit en_m);
    logic [4:0] alu_tab [8];
    logic [2:0] rd_tab  [8];
    logic [1:0] wr_tab  [8];
    logic [5:0] br_tab  [8];
    obs_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ill;
    alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    rd_tab  = '{MEM_READ_BYTE, MEM_READ_HALF, MEM_READ_WORD, MEM_READ_NONE,
                MEM_READ_BYTE_U, MEM_READ_HALF_U, MEM_READ_NONE, MEM_READ_NONE};
    wr_tab  = '{MEM_WRITE_BYTE, MEM_WRITE_HALF, MEM_WRITE_WORD, MEM_WRITE_NONE,
                MEM_WRITE_NONE, MEM_WRITE_NONE, MEM_WRITE_NONE, MEM_WRITE_NONE};
    br_tab  = '{6'd1, 6'd2, 6'd0, 6'd0, 6'd4, 6'd8, 6'd16, 6'd32};
    f3 = ins[14:12];
    f7 = ins[31:25];
    ill = 0;
    r = '0;
    r.valid = 1'b1;
    case (ins[6:0])
      OPC_LUI:    begin r.b = 1; r.imm = IMM_U; r.alu = ALU_LUI; r.wb_en = 1; end
      OPC_AUIPC:  begin r.a = 1; r.b = 1; r.imm = IMM_U; r.alu = ALU_ADD; r.wb_en = 1; end
      OPC_JAL:    begin r.a = 1; r.b = 1; r.imm = IMM_J; r.alu = ALU_ADD; r.wb_en = 1;
                        r.wb_sel = WB_SEL_PC4; r.jal = 1; end
      OPC_JALR:   begin r.b = 1; r.imm = IMM_I; r.alu = ALU_JALR_ADD; r.wb_en = 1;
                        r.wb_sel = WB_SEL_PC4; r.jal = 1; end
      OPC_BRANCH: begin r.a = 1; r.b = 1; r.imm = IMM_B; r.alu = ALU_ADD; r.br = br_tab[f3]; end
      OPC_LOAD:   begin r.b = 1; r.imm = IMM_I; r.alu = ALU_ADD; r.mr = rd_tab[f3]; r.wb_en = 1;
                        r.wb_sel = WB_SEL_MEM; end
      OPC_STORE:  begin r.b = 1; r.imm = IMM_S; r.alu = ALU_ADD; r.mw = wr_tab[f3]; end
      OPC_OP_IMM: begin r.b = 1; r.imm = IMM_I; r.wb_en = 1;
                        r.alu = (f3 == 3'd5 && ins[30]) ? ALU_SRA : alu_tab[f3]; end
      OPC_OP: begin
        r.wb_en = 1;
        if (f7 == 7'h00)                   r.alu = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) r.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) r.alu = ALU_SRA;
        else if (f7 == 7'h01 && en_m)      begin r.alu = 5'h18 + 5'(f3); r.md = 1; end
        else                               ill = 1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: ill = 1;
    endcase
    if (ill) begin
      r = '0;
      r.valid = 1'b1;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  // Occupancy model: stall is how many more cycles fetch must be held off.
  task automatic model_step(input bit en_m, input logic v, input logic f, input logic [31:0] ins,
                            inout int stall, output obs_t e);
    if (f) begin
      stall = 0;
      e = '0;
    end else if (v && stall == 0) begin
      e = ref_decode(ins, en_m);
      if (e.md) stall = ((ins[14:12] < 3'd4) ? MUL_L : DIV_L) - 1;
    end else begin
      if (stall > 0) stall--;
      e = '0;
      e.md = (stall > 0);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_bundle_m"}, 32'(obs_m), 32'(exp_m));
    check({tag, "_ready_m"}, 32'(m_in_ready), 32'(stall_m == 0));
    check({tag, "_bundle_n"}, 32'(obs_n), 32'(exp_n));
    check({tag, "_ready_n"}, 32'(n_in_ready), 32'(stall_n == 0));
  endtask

  task automatic step(input logic v, input logic f, input logic [31:0] ins, input string tag);
    in_valid = v;
    flush    = f;
    instr    = ins;
    @(posedge clk);
    model_step(1'b1, v, f, ins, stall_m, exp_m);
    model_step(1'b0, v, f, ins, stall_n, exp_n);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0:  w[6:0] = OPC_LUI;
      1:  w[6:0] = OPC_AUIPC;
      2:  w[6:0] = OPC_JAL;
      3:  begin w[6:0] = OPC_JALR; w[14:12] = 3'd0; end
      4:  w[6:0] = OPC_BRANCH;
      5:  w[6:0] = OPC_LOAD;
      6:  w[6:0] = OPC_STORE;
      7:  w[6:0] = OPC_OP_IMM;
      8:  begin w[6:0] = OPC_OP; w[31:25] = 7'h00; end
      9:  begin w[6:0] = OPC_OP; w[31:25] = 7'h20; end
      10: begin w[6:0] = OPC_OP; w[31:25] = 7'h01; end
      11: w[6:0] = OPC_OP;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; instr = '0;
    stall_m = 0; stall_n = 0; exp_m = '0; exp_n = '0;
    repeat (3) @(negedge clk);
    check_all("reset");

    rst_n = 1'b1;
    step(1, 0, I_ADD, "add");
    check("add_alu", 32'(m_ex_alu_code), 32'(ALU_ADD));
    check("add_wb_en", 32'(m_ex_wb_en), 32'd1);

    step(1, 0, I_LW, "lw");
    check("lw_mem_read", 32'(m_ex_mem_read), 32'(MEM_READ_WORD));
    check("lw_wb_sel", 32'(m_ex_wb_sel), 32'(WB_SEL_MEM));
    step(0, 0, I_LW, "bubble");
    check("bubble_zero", 32'(obs_m), 32'd0);

    step(1, 0, I_DIV, "div");
    check("div_alu", 32'(m_ex_alu_code), 32'(ALU_DIV));
    lows = 0;
    while (m_in_ready === 1'b0 && lows < 100) begin
      lows++;
      step(1, 0, I_ADD, "div_wait");
    end
    check("div_ready_low_cycles", 32'(lows), 32'(DIV_L - 1));
    step(1, 0, I_ADD, "add_after_div");
    check("add_after_div_valid", 32'(m_ex_valid), 32'd1);

    step(1, 0, I_DIV, "div2");
    repeat (4) step(0, 0, I_ADD, "div2_busy");
    step(1, 1, I_ADD, "flush");
    check("flush_ready", 32'(m_in_ready), 32'd1);
    check("flush_md_busy", 32'(m_ex_md_busy), 32'd0);
    check("flush_valid", 32'(m_ex_valid), 32'd0);
    step(1, 0, I_ADD, "post_flush_add");
    check("post_flush_valid", 32'(m_ex_valid), 32'd1);

    step(1, 0, I_MUL, "mul");
    check("mul_illegal_n", 32'(n_ex_illegal), 32'd1);
    check("mul_wb_en_n", 32'(n_ex_wb_en), 32'd0);
    check("mul_md_busy_m", 32'(m_ex_md_busy), 32'd1);
    step(1, 0, I_BAD, "bad_opcode");
    step(1, 0, I_BAD, "bad_opcode2");
    check("bad_opcode_illegal_m", 32'(m_ex_illegal), 32'd1);

    step(1, 0, I_DIV, "div3");
    repeat (3) step(0, 0, I_ADD, "div3_busy");
    #2 rst_n = 1'b0;
    stall_m = 0; stall_n = 0; exp_m = '0; exp_n = '0;
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, I_ADD, "add_after_reset");

    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0),
           rand_instr(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
